// File: rtl/dmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_if
//   Bundle between the two data-memory requesters, the arbiter and the shared
//   data memory.
//
//   Requester n (0 = pipeline load/store, 1 = DMA/debug):
//     reqN     request, held with its payload until gntN
//     weN      1 = store, 0 = load
//     funct3N  RISC-V access size / sign code
//     addrN    byte address
//     wdataN   store data
//     gntN     request accepted (combinational, IDLE only)
//     doneN    one-cycle completion pulse
//     errN     one-cycle rejection pulse, coincident with doneN
//     rdataN   last load result for this requester
//
//   Memory side:
//     MemRead, MemWrite, funct3, address, write_data   driven by the arbiter
//     read_data   combinational read result (sized/sign-extended by memory)
//
//   Modports: slave = the arbiter; master = requesters plus memory model.
// ---------------------------------------------------------------------------
interface dmem_arbiter_if;
  logic        req0;
  logic        we0;
  logic [2:0]  funct30;
  logic [31:0] addr0;
  logic [31:0] wdata0;
  logic        gnt0;
  logic        done0;
  logic        err0;
  logic [31:0] rdata0;

  logic        req1;
  logic        we1;
  logic [2:0]  funct31;
  logic [31:0] addr1;
  logic [31:0] wdata1;
  logic        gnt1;
  logic        done1;
  logic        err1;
  logic [31:0] rdata1;

  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  funct3;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;

  modport slave (
    input  req0, we0, funct30, addr0, wdata0,
    input  req1, we1, funct31, addr1, wdata1,
    output gnt0, done0, err0, rdata0,
    output gnt1, done1, err1, rdata1,
    output MemRead, MemWrite, funct3, address, write_data,
    input  read_data
  );

  modport master (
    output req0, we0, funct30, addr0, wdata0,
    output req1, we1, funct31, addr1, wdata1,
    input  gnt0, done0, err0, rdata0,
    input  gnt1, done1, err1, rdata1,
    input  MemRead, MemWrite, funct3, address, write_data,
    output read_data
  );
endinterface

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//   Two-port round-robin arbiter in front of a single-ported data memory.
//   A request is granted in IDLE, performed in ACCESS, and reported in RESP,
//   so each access takes three cycles and nothing is queued while busy.
//   Requests that are out of range, misaligned, or carry an illegal funct3
//   are rejected in ACCESS without touching memory and reported with errN.
//
//   Ports:
//     clk    single clock, rising edge
//     rst    synchronous, active-high reset
//     bus    dmem_arbiter_if.slave (requesters + memory side)
//     busy   high whenever the arbiter is not in IDLE
//
//   Parameter:
//     MEM_BYTES  byte capacity of the shared memory (legal addresses
//                0..MEM_BYTES-1)
// ---------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus,
  output logic           busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // One past the last legal byte, widened so addr + size cannot wrap.
  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

  state_t      state, state_nxt;
  logic        prio;          // port that wins when both request
  logic        owner;         // port whose request is in flight
  logic        lat_we;
  logic [2:0]  lat_funct3;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic        lat_err;       // rejection decided in ACCESS, reported in RESP
  logic [31:0] rdata0_q;
  logic [31:0] rdata1_q;

  logic        grant_valid;
  logic        grant_port;

  logic [2:0]  size;
  logic [32:0] end_addr;
  logic        funct3_ok;
  logic        align_ok;
  logic        range_ok;
  logic        req_ok;

  logic        gnt0, gnt1, done0, done1, err0, err1;
  logic        mem_read, mem_write;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;

  // -------------------------------------------------------------------------
  // Arbitration: a lone requester always wins; a tie goes to prio.
  // -------------------------------------------------------------------------
  always_comb begin
    grant_valid = bus.req0 | bus.req1;
    if (bus.req0 && bus.req1) begin
      grant_port = prio;
    end else begin
      grant_port = bus.req1;
    end
  end

  // -------------------------------------------------------------------------
  // Validity of the latched request. funct3[1:0] encodes the size for both
  // signed and unsigned loads; illegal codes are caught by funct3_ok.
  // -------------------------------------------------------------------------
  always_comb begin
    case (lat_funct3[1:0])
      2'b00:   size = 3'd1;
      2'b01:   size = 3'd2;
      default: size = 3'd4;
    endcase

    end_addr = {1'b0, lat_addr} + 33'(size);
    range_ok = (end_addr <= MEM_LIMIT);

    if (lat_we) begin
      funct3_ok = lat_funct3 inside {3'b000, 3'b001, 3'b010};
    end else begin
      funct3_ok = lat_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    end

    align_ok = !(((lat_funct3[1:0] == 2'b01) && lat_addr[0]) ||
                 ((lat_funct3[1:0] == 2'b10) && (lat_addr[1:0] != 2'b00)));

    req_ok = funct3_ok && align_ok && range_ok;
  end

  // -------------------------------------------------------------------------
  // Next state and outputs.
  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt   = state;
    gnt0        = 1'b0;
    gnt1        = 1'b0;
    done0       = 1'b0;
    done1       = 1'b0;
    err0        = 1'b0;
    err1        = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_funct3  = 3'b000;
    mem_address = 32'h0;
    mem_wdata   = 32'h0;

    case (state)
      IDLE: begin
        if (grant_valid) begin
          gnt0      = !grant_port;
          gnt1      = grant_port;
          state_nxt = ACCESS;
        end
      end

      ACCESS: begin
        state_nxt = RESP;
        if (req_ok) begin
          mem_read    = !lat_we;
          mem_write   = lat_we;
          mem_funct3  = lat_funct3;
          mem_address = lat_addr;
          mem_wdata   = lat_wdata;
        end
      end

      RESP: begin
        state_nxt = IDLE;
        done0     = !owner;
        done1     = owner;
        err0      = !owner && lat_err;
        err1      = owner && lat_err;
      end

      default: state_nxt = IDLE;
    endcase

    // Reset abandons any in-flight access: no handshake and no memory strobe
    // may escape during the reset cycle itself.
    if (rst) begin
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      done0     = 1'b0;
      done1     = 1'b0;
      err0      = 1'b0;
      err1      = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // State, request latch and load-result registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      prio       <= 1'b0;
      owner      <= 1'b0;
      lat_we     <= 1'b0;
      lat_funct3 <= 3'b000;
      lat_addr   <= 32'h0;
      lat_wdata  <= 32'h0;
      lat_err    <= 1'b0;
      rdata0_q   <= 32'h0;
      rdata1_q   <= 32'h0;
    end else begin
      state <= state_nxt;

      if ((state == IDLE) && grant_valid) begin
        owner <= grant_port;
        prio  <= !grant_port;
        if (grant_port) begin
          lat_we     <= bus.we1;
          lat_funct3 <= bus.funct31;
          lat_addr   <= bus.addr1;
          lat_wdata  <= bus.wdata1;
        end else begin
          lat_we     <= bus.we0;
          lat_funct3 <= bus.funct30;
          lat_addr   <= bus.addr0;
          lat_wdata  <= bus.wdata0;
        end
      end

      if (state == ACCESS) begin
        lat_err <= !req_ok;
        // Only a successful read updates the owner's result register.
        if (req_ok && !lat_we) begin
          if (owner) begin
            rdata1_q <= bus.read_data;
          end else begin
            rdata0_q <= bus.read_data;
          end
        end
      end
    end
  end

  assign bus.gnt0       = gnt0;
  assign bus.gnt1       = gnt1;
  assign bus.done0      = done0;
  assign bus.done1      = done1;
  assign bus.err0       = err0;
  assign bus.err1       = err1;
  assign bus.rdata0     = rdata0_q;
  assign bus.rdata1     = rdata1_q;
  assign bus.MemRead    = mem_read;
  assign bus.MemWrite   = mem_write;
  assign bus.funct3     = mem_funct3;
  assign bus.address    = mem_address;
  assign bus.write_data = mem_wdata;

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//   Directed bench for dmem_arbiter with a 1 KiB byte-addressed memory model
//   that performs RISC-V sized, sign/zero-extended reads combinationally and
//   sized writes on the clock edge.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

  logic clk;
  logic rst;
  logic busy;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.MEM_BYTES(1024)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- memory model ----------------
  logic [7:0]  mem [0:1023] = '{default: 8'h00};
  logic [31:0] ma;
  logic [7:0]  mb0, mb1, mb2, mb3;

  always_comb begin
    ma  = bus.address;
    mb0 = (ma < 32'd1024) ? mem[ma[9:0]]         : 8'h00;
    mb1 = (ma < 32'd1023) ? mem[ma[9:0] + 10'd1] : 8'h00;
    mb2 = (ma < 32'd1022) ? mem[ma[9:0] + 10'd2] : 8'h00;
    mb3 = (ma < 32'd1021) ? mem[ma[9:0] + 10'd3] : 8'h00;
    case (bus.funct3)
      3'b000:  bus.read_data = {{24{mb0[7]}}, mb0};
      3'b001:  bus.read_data = {{16{mb1[7]}}, mb1, mb0};
      3'b010:  bus.read_data = {mb3, mb2, mb1, mb0};
      3'b100:  bus.read_data = {24'h0, mb0};
      3'b101:  bus.read_data = {16'h0, mb1, mb0};
      default: bus.read_data = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (bus.MemWrite) begin
      for (int k = 0; k < 4; k++) begin
        if (((bus.funct3[1:0] == 2'b00 && k < 1) ||
             (bus.funct3[1:0] == 2'b01 && k < 2) ||
             (bus.funct3[1:0] == 2'b10)) &&
            (bus.address + 32'(k) < 32'd1024)) begin
          mem[10'(bus.address + 32'(k))] <= bus.write_data[8*k +: 8];
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  typedef struct {
    logic        g;
    logic        g_oth;
    logic        mrd;
    logic        mwr;
    logic [2:0]  mf3;
    logic [31:0] maddr;
    logic [31:0] mwd;
    logic        dn;
    logic        er;
    logic        dn_oth;
    logic [31:0] rd;
  } obs_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit port, input bit on, input bit we,
                         input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d);
    if (!port) begin
      bus.req0 = on; bus.we0 = we; bus.funct30 = f3; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = on; bus.we1 = we; bus.funct31 = f3; bus.addr1 = a; bus.wdata1 = d;
    end
  endtask

  // One full transaction from IDLE: request at T, sample at T, T+1, T+2.
  task automatic do_access(input bit port, input bit we, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] d,
                           output obs_t o);
    set_req(port, 1'b1, we, f3, a, d);
    @(negedge clk);
    o.g     = port ? bus.gnt1 : bus.gnt0;
    o.g_oth = port ? bus.gnt0 : bus.gnt1;
    tick();
    set_req(port, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    o.mrd   = bus.MemRead;
    o.mwr   = bus.MemWrite;
    o.mf3   = bus.funct3;
    o.maddr = bus.address;
    o.mwd   = bus.write_data;
    tick();
    @(negedge clk);
    o.dn     = port ? bus.done1 : bus.done0;
    o.er     = port ? bus.err1  : bus.err0;
    o.dn_oth = port ? bus.done0 : bus.done1;
    o.rd     = port ? bus.rdata1 : bus.rdata0;
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    set_req(1'b0, 1'b1, 1'b0, 3'b010, 32'h0, 32'h0);
    tick();
    tick();
    @(negedge clk);
    n_checks++; if (bus.gnt0 !== 1'b0) $display("FAIL rst_gnt0: got %b want 0", bus.gnt0); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (bus.rdata0 !== 32'h0 || bus.rdata1 !== 32'h0)
      $display("FAIL rst_rdata: got %h/%h want 0/0", bus.rdata0, bus.rdata1); else n_pass++;
    n_checks++; if (bus.MemRead !== 1'b0 || bus.MemWrite !== 1'b0)
      $display("FAIL rst_mem: got rd=%b wr=%b want 0/0", bus.MemRead, bus.MemWrite); else n_pass++;
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.gnt0 !== 1'b1) $display("FAIL post_rst_gnt0: got %b want 1", bus.gnt0); else n_pass++;
    tick();
    set_req(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    n_checks++; if (bus.MemRead !== 1'b1) $display("FAIL post_rst_memread: got %b want 1", bus.MemRead); else n_pass++;
    tick();
    @(negedge clk);
    n_checks++; if (bus.done0 !== 1'b1) $display("FAIL post_rst_done0: got %b want 1", bus.done0); else n_pass++;
    tick();
  endtask

  task automatic test_sw_lw();
    obs_t o;
    do_access(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, o);
    n_checks++; if (o.g !== 1'b1 || o.g_oth !== 1'b0) $display("FAIL sw_gnt: got %b/%b want 1/0", o.g, o.g_oth); else n_pass++;
    n_checks++; if (o.mwr !== 1'b1 || o.mrd !== 1'b0) $display("FAIL sw_strobes: got wr=%b rd=%b want 1/0", o.mwr, o.mrd); else n_pass++;
    n_checks++; if (o.maddr !== 32'h10 || o.mwd !== 32'hDEADBEEF || o.mf3 !== 3'b010)
      $display("FAIL sw_bus: got a=%h d=%h f3=%b want 10/deadbeef/010", o.maddr, o.mwd, o.mf3); else n_pass++;
    n_checks++; if (o.dn !== 1'b1 || o.er !== 1'b0) $display("FAIL sw_done: got dn=%b er=%b want 1/0", o.dn, o.er); else n_pass++;
    do_access(1'b0, 1'b0, 3'b010, 32'h10, 32'h0, o);
    n_checks++; if (o.g !== 1'b1) $display("FAIL lw_gnt0: got %b want 1", o.g); else n_pass++;
    n_checks++; if (o.mrd !== 1'b1 || o.mwr !== 1'b0) $display("FAIL lw_strobes: got rd=%b wr=%b want 1/0", o.mrd, o.mwr); else n_pass++;
    n_checks++; if (o.dn !== 1'b1 || o.rd !== 32'hDEADBEEF)
      $display("FAIL lw_rdata0: got dn=%b rd=%h want 1/deadbeef", o.dn, o.rd); else n_pass++;
  endtask

  task automatic test_round_robin();
    int n_both;
    int n_grants;
    int g_cyc [0:7];
    bit g_port [0:7];
    logic busy_c0, busy_c1;
    n_both   = 0;
    n_grants = 0;
    busy_c0  = 1'b0;
    busy_c1  = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(1'b0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    set_req(1'b1, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 0) busy_c0 = busy;
      if (c == 1) busy_c1 = busy;
      if (bus.gnt0 && bus.gnt1) n_both++;
      if ((bus.gnt0 || bus.gnt1) && n_grants < 8) begin
        g_cyc[n_grants]  = c;
        g_port[n_grants] = bus.gnt1;
        n_grants++;
      end
      tick();
    end
    set_req(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    set_req(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    n_checks++; if (n_both !== 0) $display("FAIL rr_both_gnt: got %0d cycles want 0", n_both); else n_pass++;
    n_checks++; if (n_grants !== 4) $display("FAIL rr_count: got %0d want 4", n_grants); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      if (i < n_grants) begin
        n_checks++; if (g_cyc[i] !== 3 * i || g_port[i] !== i[0])
          $display("FAIL rr_grant%0d: got cyc=%0d port=%0d want cyc=%0d port=%0d",
                   i, g_cyc[i], g_port[i], 3 * i, i % 2); else n_pass++;
      end
    end
    n_checks++; if (busy_c0 !== 1'b0 || busy_c1 !== 1'b1)
      $display("FAIL rr_busy: got %b/%b want 0/1", busy_c0, busy_c1); else n_pass++;
    n_checks++; if (bus.rdata1 !== 32'hDEADBEEF) $display("FAIL rr_rdata1: got %h want deadbeef", bus.rdata1); else n_pass++;
  endtask

  task automatic test_misaligned();
    obs_t o;
    do_access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, o);
    n_checks++; if (o.rd !== 32'hDEADBEEF) $display("FAIL mis_pre_rdata1: got %h want deadbeef", o.rd); else n_pass++;
    do_access(1'b1, 1'b0, 3'b001, 32'h21, 32'h0, o);
    n_checks++; if (o.g !== 1'b1) $display("FAIL mis_gnt1: got %b want 1", o.g); else n_pass++;
    n_checks++; if (o.mrd !== 1'b0 || o.mwr !== 1'b0) $display("FAIL mis_strobes: got rd=%b wr=%b want 0/0", o.mrd, o.mwr); else n_pass++;
    n_checks++; if (o.dn !== 1'b1 || o.er !== 1'b1 || o.dn_oth !== 1'b0)
      $display("FAIL mis_done_err: got dn=%b er=%b dn0=%b want 1/1/0", o.dn, o.er, o.dn_oth); else n_pass++;
    n_checks++; if (o.rd !== 32'hDEADBEEF) $display("FAIL mis_rdata1_kept: got %h want deadbeef", o.rd); else n_pass++;
  endtask

  task automatic test_boundary();
    obs_t o;
    do_access(1'b1, 1'b1, 3'b000, 32'h3FF, 32'h80, o);
    n_checks++; if (o.mwr !== 1'b1 || o.er !== 1'b0 || o.dn !== 1'b1)
      $display("FAIL sb_3ff: got wr=%b er=%b dn=%b want 1/0/1", o.mwr, o.er, o.dn); else n_pass++;
    do_access(1'b1, 1'b0, 3'b000, 32'h3FF, 32'h0, o);
    n_checks++; if (o.rd !== 32'hFFFFFF80 || o.er !== 1'b0)
      $display("FAIL lb_3ff: got rd=%h er=%b want ffffff80/0", o.rd, o.er); else n_pass++;
    do_access(1'b1, 1'b0, 3'b100, 32'h3FF, 32'h0, o);
    n_checks++; if (o.rd !== 32'h00000080 || o.er !== 1'b0)
      $display("FAIL lbu_3ff: got rd=%h er=%b want 00000080/0", o.rd, o.er); else n_pass++;
    do_access(1'b1, 1'b0, 3'b010, 32'h3FC, 32'h0, o);
    n_checks++; if (o.rd !== 32'h80000000 || o.er !== 1'b0)
      $display("FAIL lw_3fc: got rd=%h er=%b want 80000000/0", o.rd, o.er); else n_pass++;
    do_access(1'b1, 1'b1, 3'b010, 32'h3FE, 32'h12345678, o);
    n_checks++; if (o.er !== 1'b1 || o.dn !== 1'b1 || o.mwr !== 1'b0)
      $display("FAIL sw_3fe: got er=%b dn=%b wr=%b want 1/1/0", o.er, o.dn, o.mwr); else n_pass++;
    n_checks++; if (o.rd !== 32'h80000000) $display("FAIL sw_3fe_rdata1: got %h want 80000000", o.rd); else n_pass++;
    do_access(1'b0, 1'b1, 3'b100, 32'h20, 32'h55, o);
    n_checks++; if (o.er !== 1'b1 || o.mwr !== 1'b0)
      $display("FAIL store_f3_100: got er=%b wr=%b want 1/0", o.er, o.mwr); else n_pass++;
  endtask

  task automatic test_reset_abort();
    obs_t o;
    do_access(1'b0, 1'b1, 3'b010, 32'h40, 32'h11223344, o);
    n_checks++; if (o.dn !== 1'b1 || o.er !== 1'b0) $display("FAIL abort_pre_sw: got dn=%b er=%b want 1/0", o.dn, o.er); else n_pass++;
    set_req(1'b0, 1'b1, 1'b1, 3'b010, 32'h40, 32'hCAFEF00D);
    @(negedge clk);
    n_checks++; if (bus.gnt0 !== 1'b1) $display("FAIL abort_gnt0: got %b want 1", bus.gnt0); else n_pass++;
    tick();
    set_req(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.MemWrite !== 1'b0 || bus.done0 !== 1'b0)
      $display("FAIL abort_access: got wr=%b dn=%b want 0/0", bus.MemWrite, bus.done0); else n_pass++;
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || bus.done0 !== 1'b0)
      $display("FAIL abort_idle: got busy=%b dn=%b want 0/0", busy, bus.done0); else n_pass++;
    tick();
    do_access(1'b0, 1'b0, 3'b010, 32'h40, 32'h0, o);
    n_checks++; if (o.rd !== 32'h11223344) $display("FAIL abort_readback: got %h want 11223344", o.rd); else n_pass++;
  endtask

  // ---------------- sequence ----------------
  initial begin
    rst = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    set_req(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    test_reset();
    test_sw_lw();
    test_round_robin();
    test_misaligned();
    test_boundary();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: MEM_BYTES, default 1024, byte capacity of the shared data memory; legal addresses are 0..MEM_BYTES-1.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Ports, requester n in {0,1} (0 = pipeline load/store, 1 = DMA/debug): reqN input 1 access request; weN input 1 write=1/read=0; funct3N input 3 access size/sign code; addrN input 32 byte address; wdataN input 32 store data.
REQ-005 Ports, requester n: gntN output 1 request accepted; doneN output 1 access complete; errN output 1 access rejected; rdataN output 32 load result.
REQ-006 Memory side: MemRead output 1; MemWrite output 1; funct3 output 3; address output 32; write_data output 32; read_data input 32 (combinational memory read result).
REQ-007 Port: busy  output  1  arbiter not in IDLE.

Function
REQ-008 FSM states IDLE, ACCESS, RESP; reset state IDLE.
REQ-009 IDLE: if any reqN high, grant exactly one port; gntN high combinationally that cycle; latch we, funct3, addr, wdata, and owner; next state ACCESS.
REQ-010 Arbitration: round-robin pointer prio (reset 0); both requesting -> grant port prio; single requester -> grant it regardless of prio; after a grant, prio <= other port.
REQ-011 gnt0 and gnt1 never high in the same cycle; gntN only in IDLE.
REQ-012 Requester holds reqN and payload stable until gntN; may drop or change it the cycle after gntN.
REQ-013 Validity check on latched request in ACCESS: reject if addr >= MEM_BYTES-size+1, write funct3 not in {000,001,010}, read funct3 not in {000,001,010,100,101}, halfword with addr[0]=1, or word with addr[1:0]!=0.
REQ-014 ACCESS, valid request: drive address, funct3, write_data from latched values; MemWrite = we, MemRead = !we; capture read_data into owner's rdata register at the end of the cycle (reads).
REQ-015 ACCESS, invalid request: MemRead=MemWrite=0; memory untouched.
REQ-016 ACCESS always -> RESP next cycle.
REQ-017 RESP: one-cycle pulse doneN to owner; errN pulsed with doneN if rejected; next state IDLE.
REQ-018 Latency: gnt at cycle T, memory access at T+1, done/rdata valid at T+2; max one access per 3 cycles.
REQ-019 rdataN holds last captured load value until the next read completes for that port; writes and errors leave rdataN unchanged.
REQ-020 Outside ACCESS, MemRead, MemWrite, funct3, address, write_data are 0.
REQ-021 busy = (state != IDLE).
REQ-022 Requests arriving in ACCESS/RESP are ignored until IDLE; no queueing.

Reset
REQ-023 rst high: state IDLE, prio 0, all latched request fields 0, rdata0=rdata1=0.
REQ-024 While rst is high, gnt, done, err, MemRead, MemWrite are forced 0 combinationally, so an access in progress is abandoned and no write reaches memory.
REQ-025 First cycle after rst deasserts, a pending req is granted normally.

Verification
REQ-026 Port0 SW addr 0x10 data 0xDEADBEEF, then port0 LW 0x10 -> gnt0 T, MemWrite at T+1, done0 T+2; read returns rdata0=0xDEADBEEF at its done0.
REQ-027 req0 and req1 high together after reset, held -> grants 0,1,0,1 alternating; never both gnt in one cycle.
REQ-028 Port1 LH addr 0x21 -> err1 and done1 at T+2, MemRead/MemWrite stay 0, rdata1 unchanged.
REQ-029 Port1 SB addr 0x3FF data 0x80, then LB 0x3FF -> rdata1=0xFFFFFF80; LBU -> 0x00000080; SW 0x3FE -> err1.
REQ-030 rst asserted in ACCESS cycle of a SW -> MemWrite 0, no done, state IDLE, later LW same address returns prior contents.
